// File: rtl/hazard_pkg.sv
// Shared encodings and scoreboard types for the pipeline hazard controller.
package hazard_pkg;

  localparam logic [1:0] WSRC_ALU = 2'd0;
  localparam logic [1:0] WSRC_MEM = 2'd1;
  localparam logic [1:0] WSRC_PC4 = 2'd2;
  localparam logic [1:0] WSRC_IMM = 2'd3;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_MEMWAIT = 2'd3
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic [1:0] wsrc;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // Entry whose result is not available from the ALU path one stage later.
  function automatic logic produces_late(sb_entry_t e);
    return e.valid && e.reg_write && (e.rd != 5'd0) && (e.wsrc != WSRC_ALU);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Per-operand forwarding comparator: M has priority over W, x0 never forwards.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic       m_valid_i,
  input  logic       m_reg_write_i,
  input  logic [4:0] m_rd_i,
  input  logic       m_alu_i,
  input  logic       w_valid_i,
  input  logic       w_reg_write_i,
  input  logic [4:0] w_rd_i,
  output logic [1:0] fwd_o
);

  logic m_hit;
  logic w_hit;

  // Select the youngest producer that can supply a valid operand value.
  always_comb begin
    m_hit = m_valid_i && m_reg_write_i && (m_rd_i != 5'd0) && (m_rd_i == rs_i) && m_alu_i;
    w_hit = w_valid_i && w_reg_write_i && (w_rd_i != 5'd0) && (w_rd_i == rs_i);
    fwd_o = FWD_RF;
    if (m_hit) begin
      fwd_o = FWD_M;
    end else if (w_hit) begin
      fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow E/M/W scoreboard, forwarding, stalls, flushes.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  rs1D_i,
  input  logic [4:0]  rs2D_i,
  input  logic [4:0]  rdD_i,
  input  logic        RegWriteD_i,
  input  logic [1:0]  WriteSrcD_i,
  input  logic        PCsrcM_i,
  input  logic        mem_busy_i,
  output logic [1:0]  ForwardAE_o,
  output logic [1:0]  ForwardBE_o,
  output logic        StallF_o,
  output logic        StallD_o,
  output logic        StallE_o,
  output logic        StallM_o,
  output logic        FlushD_o,
  output logic        FlushE_o,
  output logic        FlushM_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o
);

  sb_entry_t   e_q, e_d, m_q, m_d;
  logic [4:0]  e_rs1_q, e_rs1_d, e_rs2_q, e_rs2_d;
  // W only needs the match fields: ResultW already covers every write-back source.
  logic        w_valid_q, w_valid_d, w_rw_q, w_rw_d;
  logic [4:0]  w_rd_q, w_rd_d;
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        use_hazard;
  logic        freeze;

  fwd_select u_fwd_a (
    .rs_i          (e_rs1_q),
    .m_valid_i     (m_q.valid),
    .m_reg_write_i (m_q.reg_write),
    .m_rd_i        (m_q.rd),
    .m_alu_i       (m_q.wsrc == WSRC_ALU),
    .w_valid_i     (w_valid_q),
    .w_reg_write_i (w_rw_q),
    .w_rd_i        (w_rd_q),
    .fwd_o         (ForwardAE_o)
  );

  fwd_select u_fwd_b (
    .rs_i          (e_rs2_q),
    .m_valid_i     (m_q.valid),
    .m_reg_write_i (m_q.reg_write),
    .m_rd_i        (m_q.rd),
    .m_alu_i       (m_q.wsrc == WSRC_ALU),
    .w_valid_i     (w_valid_q),
    .w_reg_write_i (w_rw_q),
    .w_rd_i        (w_rd_q),
    .fwd_o         (ForwardBE_o)
  );

  // Prioritised control decode and next scoreboard contents.
  always_comb begin
    use_hazard = produces_late(e_q) && ((e_q.rd == rs1D_i) || (e_q.rd == rs2D_i));

    state_d  = ST_RUN;
    StallF_o = 1'b0;
    StallD_o = 1'b0;
    StallE_o = 1'b0;
    StallM_o = 1'b0;
    FlushD_o = 1'b0;
    FlushE_o = 1'b0;
    FlushM_o = 1'b0;

    if (mem_busy_i) begin
      state_d  = ST_MEMWAIT;
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      StallE_o = 1'b1;
      StallM_o = 1'b1;
    end else if (PCsrcM_i) begin
      state_d  = ST_FLUSH;
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
      FlushM_o = 1'b1;
    end else if (use_hazard) begin
      state_d  = ST_LDSTALL;
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      FlushE_o = 1'b1;
    end

    freeze = (state_d == ST_MEMWAIT);

    e_d       = e_q;
    e_rs1_d   = e_rs1_q;
    e_rs2_d   = e_rs2_q;
    m_d       = m_q;
    w_valid_d = w_valid_q;
    w_rw_d    = w_rw_q;
    w_rd_d    = w_rd_q;

    if (!freeze) begin
      w_valid_d = m_q.valid;
      w_rw_d    = m_q.reg_write;
      w_rd_d    = m_q.rd;
      m_d       = FlushM_o ? SB_BUBBLE : e_q;
      // FlushE_o already covers the load-use bubble case.
      if (FlushE_o) begin
        e_d     = SB_BUBBLE;
        e_rs1_d = 5'd0;
        e_rs2_d = 5'd0;
      end else begin
        e_d.valid     = 1'b1;
        e_d.rd        = rdD_i;
        e_d.reg_write = RegWriteD_i;
        e_d.wsrc      = WriteSrcD_i;
        e_rs1_d       = rs1D_i;
        e_rs2_d       = rs2D_i;
      end
    end

    cnt_d = cnt_q;
    if (StallF_o || StallD_o || StallE_o || StallM_o) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // State, scoreboard and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_RUN;
      e_q       <= SB_BUBBLE;
      e_rs1_q   <= '0;
      e_rs2_q   <= '0;
      m_q       <= SB_BUBBLE;
      w_valid_q <= 1'b0;
      w_rw_q    <= 1'b0;
      w_rd_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      e_q       <= e_d;
      e_rs1_q   <= e_rs1_d;
      e_rs2_q   <= e_rs2_d;
      m_q       <= m_d;
      w_valid_q <= w_valid_d;
      w_rw_q    <= w_rw_d;
      w_rd_q    <= w_rd_d;
      cnt_q     <= cnt_d;
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a pipeline-array reference model.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd;
  logic        wr;
  logic [1:0]  ws;
  logic        pc, busy;
  logic [1:0]  fwd_a, fwd_b;
  logic        sf, sd, se, sm, fd, fe, fm;
  logic [1:0]  state;
  logic [31:0] cnt;
  logic [6:0]  ctrl;

  int compared;
  int failed;

  typedef struct packed {
    bit       v;
    bit [4:0] rd;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       wr;
    bit [1:0] ws;
  } ent_t;

  // Reference pipeline: index 0 = E, 1 = M, 2 = W.
  ent_t        pipe [3];
  int unsigned m_cnt;
  int unsigned m_state;

  hazard_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rs1D_i      (rs1),
    .rs2D_i      (rs2),
    .rdD_i       (rd),
    .RegWriteD_i (wr),
    .WriteSrcD_i (ws),
    .PCsrcM_i    (pc),
    .mem_busy_i  (busy),
    .ForwardAE_o (fwd_a),
    .ForwardBE_o (fwd_b),
    .StallF_o    (sf),
    .StallD_o    (sd),
    .StallE_o    (se),
    .StallM_o    (sm),
    .FlushD_o    (fd),
    .FlushE_o    (fe),
    .FlushM_o    (fm),
    .state_o     (state),
    .stall_cnt_o (cnt)
  );

  assign ctrl = {sf, sd, se, sm, fd, fe, fm};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit writes_reg(input ent_t e, input bit [4:0] r);
    return e.v && e.wr && (e.rd != 5'd0) && (e.rd == r);
  endfunction

  // 3 = memory wait, 2 = flush, 1 = load-use stall, 0 = run
  function automatic int unsigned exp_sel();
    ent_t e;
    e = pipe[0];
    if (busy) return 3;
    if (pc) return 2;
    if (e.v && e.wr && e.rd != 5'd0 && e.ws != 2'd0 && (e.rd == rs1 || e.rd == rs2)) return 1;
    return 0;
  endfunction

  function automatic logic [6:0] exp_ctrl(input int unsigned sel);
    case (sel)
      3:       return 7'b1111000;
      2:       return 7'b0000111;
      1:       return 7'b1100010;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [1:0] exp_fwd(input bit [4:0] r);
    if (writes_reg(pipe[1], r) && pipe[1].ws == 2'd0) return 2'b10;
    if (writes_reg(pipe[2], r)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    m_cnt   = 0;
    m_state = 0;
  endtask

  // Advance the model with the inputs currently applied, then cross one edge.
  task automatic tick();
    int unsigned sel;
    ent_t d;
    sel = exp_sel();
    d = '{v: 1'b1, rd: rd, rs1: rs1, rs2: rs2, wr: wr, ws: ws};
    if (sel != 3) begin
      pipe[2] = pipe[1];
      pipe[1] = (sel == 2) ? ent_t'('0) : pipe[0];
      pipe[0] = (sel == 2 || sel == 1) ? ent_t'('0) : d;
    end
    if (sel == 3 || sel == 1) m_cnt = m_cnt + 1;
    m_state = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                     input logic w, input logic [1:0] s, input logic p, input logic m);
    rs1 = a; rs2 = b; rd = d; wr = w; ws = s; pc = p; busy = m;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    compared++; if (ctrl !== 7'b0) begin failed++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, 7'b0); end
    compared++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin failed++; $display("FAIL reset_fwd got=%b/%b exp=00/00", fwd_a, fwd_b); end
    compared++; if (state !== 2'd0 || cnt !== 32'd0) begin failed++; $display("FAIL reset_state got=%0d cnt=%0d exp=0/0", state, cnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_alu_fwd_m();
    do_reset();
    drv(1, 2, 5, 1, 0, 0, 0); tick();
    drv(5, 1, 6, 1, 0, 0, 0);
    compared++; if (ctrl !== 7'b0) begin failed++; $display("FAIL alu_m_nostall got=%b exp=%b", ctrl, 7'b0); end
    tick();
    compared++; if (fwd_a !== 2'b10) begin failed++; $display("FAIL alu_m_fwdA got=%b exp=10", fwd_a); end
    compared++; if (fwd_b !== 2'b00) begin failed++; $display("FAIL alu_m_fwdB got=%b exp=00", fwd_b); end
  endtask

  task automatic test_fwd_w();
    do_reset();
    drv(0, 0, 5, 1, 0, 0, 0); tick();
    drv(0, 0, 0, 1, 0, 0, 0); tick();
    drv(5, 5, 7, 1, 0, 0, 0); tick();
    compared++; if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin failed++; $display("FAIL fwd_w got=%b/%b exp=01/01", fwd_a, fwd_b); end
    drv(0, 0, 5, 1, 0, 0, 0); tick();
    drv(0, 0, 5, 1, 0, 0, 0); tick();
    drv(5, 5, 7, 1, 0, 0, 0); tick();
    compared++; if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin failed++; $display("FAIL fwd_m_prio got=%b/%b exp=10/10", fwd_a, fwd_b); end
  endtask

  task automatic test_load_use();
    do_reset();
    drv(1, 0, 5, 1, 1, 0, 0); tick();
    drv(5, 2, 6, 1, 0, 0, 0);
    compared++; if (ctrl !== 7'b1100010) begin failed++; $display("FAIL lu_stall got=%b exp=%b", ctrl, 7'b1100010); end
    tick();
    compared++; if (state !== 2'd1) begin failed++; $display("FAIL lu_state got=%0d exp=1", state); end
    compared++; if (ctrl !== 7'b0) begin failed++; $display("FAIL lu_single got=%b exp=%b", ctrl, 7'b0); end
    compared++; if (cnt !== 32'd1) begin failed++; $display("FAIL lu_cnt got=%0d exp=1", cnt); end
    tick();
    compared++; if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin failed++; $display("FAIL lu_fwd got=%b/%b exp=01/00", fwd_a, fwd_b); end
    compared++; if (state !== 2'd0 || cnt !== 32'd1) begin failed++; $display("FAIL lu_after got=%0d cnt=%0d exp=0/1", state, cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drv(1, 0, 5, 1, 1, 0, 0); tick();
    drv(5, 0, 7, 1, 1, 0, 0);
    compared++; if (ctrl !== 7'b1100010) begin failed++; $display("FAIL b2b_stall1 got=%b exp=%b", ctrl, 7'b1100010); end
    tick();
    compared++; if (ctrl !== 7'b0) begin failed++; $display("FAIL b2b_release1 got=%b exp=%b", ctrl, 7'b0); end
    tick();
    compared++; if (fwd_a !== 2'b01) begin failed++; $display("FAIL b2b_fwd1 got=%b exp=01", fwd_a); end
    drv(7, 0, 8, 1, 0, 0, 0);
    compared++; if (ctrl !== 7'b1100010) begin failed++; $display("FAIL b2b_stall2 got=%b exp=%b", ctrl, 7'b1100010); end
    tick();
    compared++; if (ctrl !== 7'b0) begin failed++; $display("FAIL b2b_release2 got=%b exp=%b", ctrl, 7'b0); end
    tick();
    compared++; if (fwd_a !== 2'b01 || cnt !== 32'd2) begin failed++; $display("FAIL b2b_fwd2 got=%b cnt=%0d exp=01 cnt=2", fwd_a, cnt); end
  endtask

  task automatic test_branch();
    do_reset();
    drv(0, 0, 5, 1, 0, 0, 0); tick();
    drv(0, 0, 6, 1, 0, 0, 0); tick();
    drv(5, 6, 9, 1, 0, 1, 0);
    compared++; if (ctrl !== 7'b0000111) begin failed++; $display("FAIL br_flush got=%b exp=%b", ctrl, 7'b0000111); end
    tick();
    compared++; if (state !== 2'd2) begin failed++; $display("FAIL br_state got=%0d exp=2", state); end
    drv(5, 6, 9, 1, 0, 0, 0);
    compared++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || ctrl !== 7'b0) begin failed++; $display("FAIL br_bubble1 got=%b/%b ctrl=%b exp=00/00 ctrl=0", fwd_a, fwd_b, ctrl); end
    tick();
    compared++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin failed++; $display("FAIL br_bubble2 got=%b/%b exp=00/00", fwd_a, fwd_b); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 5, 1, 0, 1, 1);
      compared++; if (ctrl !== 7'b1111000) begin failed++; $display("FAIL mw_stall%0d got=%b exp=%b", i, ctrl, 7'b1111000); end
      tick();
      compared++; if (state !== 2'd3) begin failed++; $display("FAIL mw_state%0d got=%0d exp=3", i, state); end
    end
    drv(0, 0, 5, 1, 0, 1, 0);
    compared++; if (ctrl !== 7'b0000111) begin failed++; $display("FAIL mw_flush got=%b exp=%b", ctrl, 7'b0000111); end
    compared++; if (cnt !== 32'd3) begin failed++; $display("FAIL mw_cnt got=%0d exp=3", cnt); end
    tick();
    compared++; if (state !== 2'd2) begin failed++; $display("FAIL mw_after got=%0d exp=2", state); end
  endtask

  task automatic test_x0();
    do_reset();
    drv(1, 0, 0, 1, 1, 0, 0); tick();
    drv(0, 0, 6, 1, 0, 0, 0);
    compared++; if (ctrl !== 7'b0) begin failed++; $display("FAIL x0_nostall got=%b exp=%b", ctrl, 7'b0); end
    tick();
    compared++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin failed++; $display("FAIL x0_fwd_m got=%b/%b exp=00/00", fwd_a, fwd_b); end
    drv(1, 0, 0, 1, 0, 0, 0); tick();
    drv(0, 0, 0, 1, 0, 0, 0); tick();
    drv(0, 0, 7, 1, 0, 0, 0); tick();
    compared++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin failed++; $display("FAIL x0_fwd_w got=%b/%b exp=00/00", fwd_a, fwd_b); end
  endtask

  task automatic test_reset_mid();
    drv(1, 0, 5, 1, 1, 0, 0); tick();
    drv(5, 0, 6, 1, 0, 0, 0);
    compared++; if (ctrl !== 7'b1100010) begin failed++; $display("FAIL rm_pre got=%b exp=%b", ctrl, 7'b1100010); end
    tick();
    compared++; if (state !== 2'd1 || cnt !== m_cnt) begin failed++; $display("FAIL rm_ldstall got=%0d cnt=%0d exp=1 cnt=%0d", state, cnt, m_cnt); end
    rst_n = 1'b0;
    model_reset();
    #1;
    compared++; if (ctrl !== 7'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin failed++; $display("FAIL rm_outs got=%b %b/%b exp=0 00/00", ctrl, fwd_a, fwd_b); end
    compared++; if (state !== 2'd0 || cnt !== 32'd0) begin failed++; $display("FAIL rm_state got=%0d cnt=%0d exp=0/0", state, cnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [6:0] ec;
    logic [1:0] ea, eb;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      drv(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0));
      ec = exp_ctrl(exp_sel());
      ea = exp_fwd(pipe[0].rs1);
      eb = exp_fwd(pipe[0].rs2);
      compared++; if (ctrl !== ec) begin failed++; $display("FAIL rnd_ctrl@%0d got=%b exp=%b", n, ctrl, ec); end
      compared++; if (fwd_a !== ea || fwd_b !== eb) begin failed++; $display("FAIL rnd_fwd@%0d got=%b/%b exp=%b/%b", n, fwd_a, fwd_b, ea, eb); end
      compared++; if (state !== 2'(m_state) || cnt !== m_cnt) begin failed++; $display("FAIL rnd_state@%0d got=%0d cnt=%0d exp=%0d cnt=%0d", n, state, cnt, m_state, m_cnt); end
      tick();
    end
  endtask

  initial begin
    compared = 0;
    failed   = 0;
    test_reset();
    test_alu_fwd_m();
    test_fwd_w();
    test_load_use();
    test_back_to_back();
    test_branch();
    test_mem_wait();
    test_reset_mid();
    test_x0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
